// File: rtl/alu_sequencer.sv
// Issue/writeback stage feeding a combinational 4-bit ALU: instruction FIFO, 4x4 register file, valid/ready result port.
// Optional overflow trap enabled by defining ALU_SEQ_OVF_TRAP_EN.
module alu_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_instr,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [3:0]  alu_out,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_p,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_data,
  output logic [3:0]  res_flags,
  output logic [1:0]  res_dst,
  output logic        busy,
  output logic        trap
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e        state_q;
  logic [10:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, full, empty;
  logic [10:0]   head;

  logic [3:0]    rf_q [4];
  logic [3:0]    alu_a_q, alu_b_q, alu_opcode_q;
  logic [1:0]    dst_q;
  logic [3:0]    res_data_q, res_flags_q;
  logic [1:0]    res_dst_q;
  logic          res_valid_q;
  logic          ovf_trap;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state_q == IDLE) && !empty;
  assign head     = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= in_instr;
  end

`ifdef ALU_SEQ_OVF_TRAP_EN
  logic trap_q;

  assign ovf_trap = (state_q == EXEC) && (alu_opcode_q[3:2] == 2'b01) && alu_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        trap_q <= 1'b0;
    else if (ovf_trap) trap_q <= 1'b1;
  end

  assign trap = trap_q;
`else
  assign ovf_trap = 1'b0;
  assign trap     = 1'b0;
`endif

  // LOADs retire in IDLE without leaving it; ALU ops walk IDLE -> EXEC -> RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      dst_q        <= '0;
      res_data_q   <= '0;
      res_flags_q  <= '0;
      res_dst_q    <= '0;
      res_valid_q  <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            if (head[10]) begin
              rf_q[head[5:4]] <= head[3:0];
            end else begin
              alu_a_q      <= rf_q[head[3:2]];
              alu_b_q      <= rf_q[head[1:0]];
              alu_opcode_q <= head[9:6];
              dst_q        <= head[5:4];
              state_q      <= EXEC;
            end
          end
        end
        EXEC: begin
          res_data_q  <= alu_out;
          res_flags_q <= {alu_z, alu_c, alu_v, alu_p};
          res_dst_q   <= dst_q;
          res_valid_q <= 1'b1;
          if (!ovf_trap) rf_q[dst_q] <= alu_out;
          state_q     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_flags  = res_flags_q;
  assign res_dst    = res_dst_q;
  assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural ALU closes the loop, a monitor checks every presented result.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_instr;
  logic [3:0]  alu_a, alu_b, alu_opcode;
  logic [3:0]  alu_out;
  logic        alu_z, alu_c, alu_v, alu_p;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_data, res_flags;
  logic [1:0]  res_dst;
  logic        busy;
  logic        trap;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] flags;
    logic [1:0] dst;
  } resp_t;

  resp_t expQ[$];
  int    testsRun    = 0;
  int    testsFailed = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_opcode(alu_opcode),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .alu_c     (alu_c),
    .alu_v     (alu_v),
    .alu_p     (alu_p),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flags (res_flags),
    .res_dst   (res_dst),
    .busy      (busy),
    .trap      (trap)
  );

  // Stand-in ALU: 0 AND, 1 OR, 2 XOR, 4 ADD, 5 SUB, 12 EQ; P means strictly positive.
  logic [4:0] sum;
  always_comb begin
    sum     = '0;
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_opcode)
      4'd0: alu_out = alu_a & alu_b;
      4'd1: alu_out = alu_a | alu_b;
      4'd2: alu_out = alu_a ^ alu_b;
      4'd4: begin
        sum     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = sum[3:0];
        alu_c   = sum[4];
        alu_v   = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
      end
      4'd5: begin
        sum     = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out = sum[3:0];
        alu_c   = sum[4];
        alu_v   = (alu_a[3] != alu_b[3]) && (sum[3] != alu_a[3]);
      end
      4'd12:   alu_out = {3'b000, alu_a == alu_b};
      default: alu_out = alu_a;
    endcase
    alu_z = (alu_out == 4'd0);
    alu_p = !alu_out[3] && (alu_out != 4'd0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [10:0] ld(input logic [1:0] dst, input logic [3:0] imm);
    return {1'b1, 4'b0000, dst, imm};
  endfunction

  function automatic logic [10:0] op(input logic [3:0] opc, input logic [1:0] dst,
                                     input logic [1:0] sa, input logic [1:0] sb);
    return {1'b0, opc, dst, sa, sb};
  endfunction

  task automatic expectResp(input logic [3:0] d, input logic [3:0] f, input logic [1:0] dst);
    resp_t r;
    r.data  = d;
    r.flags = f;
    r.dst   = dst;
    expQ.push_back(r);
  endtask

  // Entered and left at posedge+1; returns just after the edge that accepted the word.
  task automatic applyStimulus(input logic [10:0] instr);
    int guard = 0;
    in_valid = 1'b1;
    in_instr = instr;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) checkOutput("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int g = 0;
    while ((expQ.size() != 0 || busy) && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    checkOutput("drain_timeout", 32'(g < 300), 32'd1);
  endtask

  // Result monitor: every cycle a result is presented it must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_resp: got data %0h flags %b dst %0d, expected none", res_data, res_flags, res_dst);
      end else begin
        checkOutput("res_data",  32'(res_data),  32'(expQ[0].data));
        checkOutput("res_flags", 32'(res_flags), 32'(expQ[0].flags));
        checkOutput("res_dst",   32'(res_dst),   32'(expQ[0].dst));
        if (res_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    res_ready = 1'b0;

    repeat (5) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_instr  = 11'($urandom);
      res_ready = 1'($urandom_range(0, 1));
    end
    checkOutput("rst_res_valid", 32'(res_valid),  32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),   32'd1);
    checkOutput("rst_busy",      32'(busy),       32'd0);
    checkOutput("rst_trap",      32'(trap),       32'd0);
    checkOutput("rst_res_data",  32'({res_data, res_flags, res_dst}), 32'd0);
    checkOutput("rst_alu_regs",  32'({alu_a, alu_b, alu_opcode}),     32'd0);

    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    expectResp(4'd0, 4'b1000, 2'd0);
    applyStimulus(op(4'd4, 2'd0, 2'd0, 2'd0));
    waitDrain();

    applyStimulus(ld(2'd0, 4'd5));
    applyStimulus(ld(2'd1, 4'd12));
    waitDrain();
    expectResp(4'd1, 4'b0101, 2'd2);
    applyStimulus(op(4'd4, 2'd2, 2'd0, 2'd1));
    checkOutput("lat_t0_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("lat_t1_valid", 32'(res_valid),  32'd0);
    checkOutput("lat_t1_alu_a", 32'(alu_a),      32'd5);
    checkOutput("lat_t1_alu_b", 32'(alu_b),      32'd12);
    checkOutput("lat_t1_opc",   32'(alu_opcode), 32'd4);
    @(posedge clk); #1;
    checkOutput("lat_t2_valid", 32'(res_valid), 32'd1);
    waitDrain();
    expectResp(4'd2, 4'b0001, 2'd3);
    applyStimulus(op(4'd4, 2'd3, 2'd2, 2'd2));
    waitDrain();

    applyStimulus(ld(2'd0, 4'd5));
    applyStimulus(ld(2'd3, 4'd3));
    expectResp(4'd8, 4'b0010, 2'd2);
    applyStimulus(op(4'd4, 2'd2, 2'd0, 2'd3));
    waitDrain();
`ifdef ALU_SEQ_OVF_TRAP_EN
    checkOutput("ovf_trap", 32'(trap), 32'd1);
    expectResp(4'd6, 4'b0001, 2'd1);
`else
    checkOutput("ovf_trap", 32'(trap), 32'd0);
    expectResp(4'd13, 4'b0000, 2'd1);
`endif
    applyStimulus(op(4'd4, 2'd1, 2'd2, 2'd0));
    waitDrain();

    applyStimulus(ld(2'd0, 4'd1));
    applyStimulus(ld(2'd1, 4'd2));
    applyStimulus(ld(2'd2, 4'd3));
    waitDrain();
    res_ready = 1'b0;
    expectResp(4'd3, 4'b0001, 2'd3);
    expectResp(4'd6, 4'b0001, 2'd3);
    expectResp(4'd5, 4'b0001, 2'd3);
    expectResp(4'd6, 4'b0001, 2'd3);
    expectResp(4'd2, 4'b0001, 2'd3);
    expectResp(4'd0, 4'b1000, 2'd0);
    fork
      begin
        applyStimulus(op(4'd4, 2'd3, 2'd0, 2'd1));
        applyStimulus(op(4'd4, 2'd3, 2'd3, 2'd2));
        applyStimulus(op(4'd5, 2'd3, 2'd3, 2'd0));
        applyStimulus(op(4'd2, 2'd3, 2'd3, 2'd2));
        applyStimulus(op(4'd0, 2'd3, 2'd3, 2'd1));
        applyStimulus(op(4'd5, 2'd0, 2'd1, 2'd3));
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        checkOutput("bp_in_ready", 32'(in_ready),  32'd0);
        checkOutput("bp_busy",     32'(busy),      32'd1);
        checkOutput("bp_valid",    32'(res_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    join
    waitDrain();

    applyStimulus(ld(2'd0, 4'd7));
    applyStimulus(ld(2'd1, 4'd7));
    expectResp(4'd1, 4'b0001, 2'd3);
    applyStimulus(op(4'd12, 2'd3, 2'd0, 2'd1));
    expectResp(4'd2, 4'b0001, 2'd2);
    applyStimulus(op(4'd4, 2'd2, 2'd3, 2'd3));
    waitDrain();

    applyStimulus(op(4'd4, 2'd0, 2'd0, 2'd1));
    applyStimulus(op(4'd4, 2'd1, 2'd0, 2'd1));
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid",    32'(res_valid), 32'd0);
    checkOutput("midrst_busy",     32'(busy),      32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready),  32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("postrst_valid", 32'(res_valid), 32'd0);
    end
    checkOutput("postrst_busy", 32'(busy), 32'd0);
    checkOutput("postrst_trap", 32'(trap), 32'd0);
    expectResp(4'd0, 4'b1000, 2'd2);
    applyStimulus(op(4'd4, 2'd2, 2'd0, 2'd0));
    waitDrain();

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
